// File: rtl/sl_pipe_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sl_pipe_fifo_pkg
// Shared constants and helpers for the single-clock elastic FIFO (sl_pipe_fifo)
// and its register-pipeline sub-module (sl_shift_pipe).
//   OVF_CNT_W   : width of the saturating overflow counter
//   cnt_width() : occupancy counter width for a given buffer depth
//   valid_bit() : index of the valid flag inside a word of a given width
// -----------------------------------------------------------------------------
package sl_pipe_fifo_pkg;

    localparam int unsigned OVF_CNT_W = 16;

    // Occupancy must be able to represent DEPTH itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned valid_bit(input int unsigned width);
        return width - 1;
    endfunction

endpackage

// File: rtl/sl_shift_pipe.sv
// -----------------------------------------------------------------------------
// sl_shift_pipe
// Free-running register pipeline of NSTAGES stages (no enable, no backpressure).
// Word layout: bit WIDTH-1 is the valid flag, bits WIDTH-2:0 the payload.
// With HOLD_INVALID set, an invalid word arriving at stage 0 clears the valid
// flag but keeps the previous payload of stage 0, so idle cycles do not
// disturb the payload downstream logic may still be looking at.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset, clears every stage
//   i_data   word entering stage 0
//   o_data   word at the last stage
// -----------------------------------------------------------------------------
module sl_shift_pipe #(
    parameter int unsigned WIDTH        = 193,
    parameter int unsigned NSTAGES      = 2,
    parameter bit          HOLD_INVALID = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [NSTAGES];
    logic [WIDTH-1:0] w_stage0_d;

    always_comb begin
        w_stage0_d = i_data;
        if (HOLD_INVALID && !i_data[WIDTH-1]) begin
            w_stage0_d = {1'b0, r_stage[0][WIDTH-2:0]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NSTAGES); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= w_stage0_d;
            for (int i = 1; i < int'(NSTAGES); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[NSTAGES-1];

endmodule

// File: rtl/sl_pipe_fifo.sv
// -----------------------------------------------------------------------------
// sl_pipe_fifo
// Single-clock elastic buffer between SL processing stages. data_in passes
// through NSTAGES_IN retiming registers; valid words leaving the last stage are
// pushed into a DEPTH-entry circular buffer. A pop (rd_ready with a non-empty
// buffer) loads the head word into the first of NSTAGES_OUT output registers.
// Pushes against a full buffer with no simultaneous pop are dropped and
// recorded in the overflow status.
//
// Optional feature: define SL_PIPE_FIFO_OVF_CNT_EN to build the 16-bit
// saturating drop counter; otherwise o_ovf_count is tied to 0 while
// o_ovf_sticky still operates.
//
// Ports:
//   i_clk           clock
//   i_rst_n         asynchronous active-low reset (drops all buffered words)
//   i_data_in       input word, MSB = valid
//   i_rd_ready      consumer requests a pop this cycle
//   i_clr_ovf       synchronous clear of overflow status (wins over a drop)
//   o_data_out      output word, MSB = valid
//   o_count         buffer occupancy
//   o_empty         occupancy == 0
//   o_full          occupancy == DEPTH
//   o_almost_full   occupancy >= AFULL_LVL
//   o_ovf_sticky    a valid word was dropped since the last clear
//   o_ovf_count     number of dropped words, saturating
// Parameter constraints: DEPTH power of 2 and >= 2; NSTAGES_IN/OUT >= 1;
// AFULL_LVL in 1..DEPTH; WIDTH >= 2.
// -----------------------------------------------------------------------------
module sl_pipe_fifo
    import sl_pipe_fifo_pkg::*;
#(
    parameter int unsigned WIDTH       = 193,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned NSTAGES_IN  = 2,
    parameter int unsigned NSTAGES_OUT = 2,
    parameter int unsigned AFULL_LVL   = 14
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [WIDTH-1:0]             i_data_in,
    input  logic                         i_rd_ready,
    input  logic                         i_clr_ovf,
    output logic [WIDTH-1:0]             o_data_out,
    output logic [cnt_width(DEPTH)-1:0]  o_count,
    output logic                         o_empty,
    output logic                         o_full,
    output logic                         o_almost_full,
    output logic                         o_ovf_sticky,
    output logic [OVF_CNT_W-1:0]         o_ovf_count
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned VB    = valid_bit(WIDTH);

    logic [WIDTH-1:0] w_in_word;
    logic [WIDTH-1:0] w_out_load;
    logic             w_push_req;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_count_full;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf_sticky;

    // ---------------------------------------------------------------- input pipe
    sl_shift_pipe #(
        .WIDTH        (WIDTH),
        .NSTAGES      (NSTAGES_IN),
        .HOLD_INVALID (1'b0)
    ) u_in_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data_in),
        .o_data  (w_in_word)
    );

    // ------------------------------------------------------- push/pop decisions
    assign w_count_full = (r_count == CNT_W'(DEPTH));
    assign w_push_req   = w_in_word[VB];
    // Pop only sees words already stored: a push into an empty buffer is not
    // bypassed to the output in the same cycle.
    assign w_pop        = i_rd_ready && (r_count != '0);
    // A pop in the same cycle frees the slot the push needs when full.
    assign w_push       = w_push_req && (!w_count_full || w_pop);
    assign w_drop       = w_push_req && !w_push;

    // ---------------------------------------------------------------- storage
    // Storage is not reset: entries are only observable after being written.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_word;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // --------------------------------------------------------------- output pipe
    // On no pop an invalid word is offered; stage 0 then holds its payload.
    assign w_out_load = w_pop ? r_mem[r_rd_ptr] : '0;

    sl_shift_pipe #(
        .WIDTH        (WIDTH),
        .NSTAGES      (NSTAGES_OUT),
        .HOLD_INVALID (1'b1)
    ) u_out_pipe (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (w_out_load),
        .o_data  (o_data_out)
    );

    // ---------------------------------------------------------------- status
    assign o_count       = r_count;
    assign o_empty       = (r_count == '0);
    assign o_full        = w_count_full;
    assign o_almost_full = (r_count >= CNT_W'(AFULL_LVL));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (i_clr_ovf) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_drop) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign o_ovf_sticky = r_ovf_sticky;

`ifdef SL_PIPE_FIFO_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] r_ovf_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_count <= '0;
        end else if (i_clr_ovf) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
        end
    end

    assign o_ovf_count = r_ovf_count;
`else
    assign o_ovf_count = '0;
`endif

endmodule

// File: tb/tb_sl_pipe_fifo.sv
// -----------------------------------------------------------------------------
// tb_sl_pipe_fifo
// Self-checking bench for sl_pipe_fifo with default parameters. A queue-based
// model of the buffer and of the two register pipes is advanced on every clock
// edge and compared against all outputs; directed literal checks pin the model.
// Inputs change on the falling edge; outputs are compared 1 time unit after
// the rising edge.
// -----------------------------------------------------------------------------
module tb_sl_pipe_fifo;

    localparam int W  = 193;
    localparam int D  = 16;
    localparam int NI = 2;
    localparam int NO = 2;
    localparam int AF = 14;
    localparam int CW = $clog2(D) + 1;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  data_in;
    logic          rd_ready;
    logic          clr_ovf;
    logic [W-1:0]  data_out;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          ovf_sticky;
    logic [15:0]   ovf_count;

    int n_total = 0;
    int n_pass  = 0;

    sl_pipe_fifo #(
        .WIDTH       (W),
        .DEPTH       (D),
        .NSTAGES_IN  (NI),
        .NSTAGES_OUT (NO),
        .AFULL_LVL   (AF)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data_in     (data_in),
        .i_rd_ready    (rd_ready),
        .i_clr_ovf     (clr_ovf),
        .o_data_out    (data_out),
        .o_count       (count),
        .o_empty       (empty),
        .o_full        (full),
        .o_almost_full (almost_full),
        .o_ovf_sticky  (ovf_sticky),
        .o_ovf_count   (ovf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [255:0] act,
                                input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [W-1:0] vw(input int v);
        return {1'b1, 192'(v)};
    endfunction

    function automatic logic [W-1:0] iw(input int v);
        return {1'b0, 192'(v)};
    endfunction

    // ------------------------------------------------------------------ model
    logic [W-1:0] q_in[$];   // front = newest word in the input pipe
    logic [W-1:0] q_out[$];  // front = output stage 0, back = data_out
    logic [W-1:0] q_buf[$];  // buffered words, oldest first
    bit           m_sticky;
    int           m_ovf;

    function automatic void model_reset();
        q_in  = {};
        q_out = {};
        q_buf = {};
        for (int i = 0; i < NI; i++) q_in.push_back('0);
        for (int i = 0; i < NO; i++) q_out.push_back('0);
        m_sticky = 0;
        m_ovf    = 0;
    endfunction

    function automatic void model_step();
        logic [W-1:0] cand;
        logic [W-1:0] popped;
        logic [W-1:0] s0;
        logic [W-1:0] nxt0;
        bit           pop;
        bit           drop;
        int           sz;
        cand = q_in[NI-1];
        void'(q_in.pop_back());
        q_in.push_front(data_in);
        sz     = q_buf.size();
        pop    = rd_ready && (sz > 0);
        popped = '0;
        if (pop) popped = q_buf.pop_front();
        s0   = q_out[0];
        nxt0 = pop ? popped : {1'b0, s0[W-2:0]};
        void'(q_out.pop_back());
        q_out.push_front(nxt0);
        drop = 0;
        if (cand[W-1]) begin
            if (sz < D || pop) q_buf.push_back(cand);
            else drop = 1;
        end
        if (clr_ovf) begin
            m_sticky = 0;
            m_ovf    = 0;
        end else if (drop) begin
            m_sticky = 1;
            if (m_ovf < 65535) m_ovf++;
        end
    endfunction

    always @(negedge rst_n) model_reset();

    // Compare process: every cycle, all outputs against the model.
    always @(posedge clk) begin
        int exp_ovf;
        if (rst_n) model_step();
        #1;
`ifdef SL_PIPE_FIFO_OVF_CNT_EN
        exp_ovf = m_ovf;
`else
        exp_ovf = 0;
`endif
        chk("m_data_out", 256'(data_out), 256'(q_out[NO-1]));
        chk("m_count", 256'(count), 256'(q_buf.size()));
        chk("m_empty", 256'(empty), 256'(q_buf.size() == 0));
        chk("m_full", 256'(full), 256'(q_buf.size() == D));
        chk("m_almost_full", 256'(almost_full), 256'(q_buf.size() >= AF));
        chk("m_ovf_sticky", 256'(ovf_sticky), 256'(m_sticky));
        chk("m_ovf_count", 256'(ovf_count), 256'(exp_ovf));
    end

    // Sets inputs for the next rising edge. On return the outputs show the
    // state after the previous rising edge.
    task automatic step(input logic [W-1:0] d, input logic rd, input logic clr);
        @(negedge clk);
        data_in  = d;
        rd_ready = rd;
        clr_ovf  = clr;
    endtask

    int exp_ovf4;

    initial begin
        model_reset();
        rst_n    = 1'b0;
        data_in  = '0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
`ifdef SL_PIPE_FIFO_OVF_CNT_EN
        exp_ovf4 = 4;
`else
        exp_ovf4 = 0;
`endif
        #2;
        chk("rst_empty", 256'(empty), 256'(1));
        chk("rst_count", 256'(count), 256'(0));
        chk("rst_data_out", 256'(data_out), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: five words, then drain in order.
        for (int i = 1; i <= 5; i++) step(vw(i), 0, 0);
        step('0, 0, 0);
        step('0, 0, 0);
        step('0, 1, 0);
        chk("t1_count5", 256'(count), 256'(5));
        chk("t1_no_valid", 256'(data_out[W-1]), 256'(0));
        step('0, 1, 0);
        step('0, 1, 0);
        chk("t1_first_word", 256'(data_out), 256'(vw(1)));
        step('0, 1, 0);
        step('0, 1, 0);
        step('0, 0, 0);
        chk("t1_drained", 256'(count), 256'(0));
        chk("t1_empty", 256'(empty), 256'(1));
        repeat (4) step('0, 0, 0);

        // 2: twenty words into a 16-entry buffer.
        for (int i = 0; i < 20; i++) step(vw(101 + i), 0, 0);
        repeat (3) step('0, 0, 0);
        chk("t2_count16", 256'(count), 256'(16));
        chk("t2_full", 256'(full), 256'(1));
        chk("t2_afull", 256'(almost_full), 256'(1));
        chk("t2_sticky", 256'(ovf_sticky), 256'(1));
        chk("t2_ovf_cnt", 256'(ovf_count), 256'(exp_ovf4));
        step('0, 0, 1);
        step('0, 0, 0);
        chk("t2_clr_sticky", 256'(ovf_sticky), 256'(0));
        chk("t2_clr_cnt", 256'(ovf_count), 256'(0));

        // 3: push onto a full buffer together with a pop, then drain across wrap.
        step(vw(200), 0, 0);
        step('0, 0, 0);
        step('0, 1, 0);
        step('0, 0, 0);
        chk("t3_count16", 256'(count), 256'(16));
        chk("t3_no_drop", 256'(ovf_sticky), 256'(0));
        step('0, 1, 0);
        chk("t3_head", 256'(data_out), 256'(vw(101)));
        repeat (17) step('0, 1, 0);
        repeat (4) step('0, 0, 0);
        chk("t3_empty", 256'(empty), 256'(1));
        chk("t3_last", 256'(data_out), 256'(iw(200)));

        // 4: push and rd_ready coincide on an empty buffer.
        step(vw(300), 1, 0);
        step('0, 1, 0);
        step('0, 1, 0);
        step('0, 1, 0);
        chk("t4_count1", 256'(count), 256'(1));
        step('0, 0, 0);
        chk("t4_popped", 256'(count), 256'(0));
        step('0, 0, 0);
        chk("t4_word", 256'(data_out), 256'(vw(300)));
        step('0, 0, 0);
        chk("t4_held", 256'(data_out), 256'(iw(300)));

        // 5: alternating valid/invalid input, popped with idle gaps.
        for (int i = 0; i < 8; i++) step((i % 2 == 0) ? vw(400 + i) : iw(900 + i), 0, 0);
        step('0, 0, 0);
        step('0, 0, 0);
        chk("t5_count4", 256'(count), 256'(4));
        for (int j = 0; j < 8; j++) step('0, (j % 2 == 0), 0);
        repeat (3) step('0, 0, 0);
        chk("t5_empty", 256'(empty), 256'(1));
        chk("t5_held", 256'(data_out), 256'(iw(406)));

        // 6: asynchronous reset with seven words stored and more in flight.
        for (int i = 0; i < 7; i++) step(vw(600 + i), 0, 0);
        repeat (3) step('0, 0, 0);
        chk("t6_count7", 256'(count), 256'(7));
        step(vw(700), 0, 0);
        step(vw(701), 0, 0);
        #2;
        rst_n   = 1'b0;
        data_in = '0;
        #1;
        chk("t6_rst_count", 256'(count), 256'(0));
        chk("t6_rst_empty", 256'(empty), 256'(1));
        chk("t6_rst_full", 256'(full), 256'(0));
        chk("t6_rst_data", 256'(data_out), 256'(0));
        step('0, 0, 0);
        step('0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step('0, 1, 0);
            chk("t6_nothing_out", 256'(data_out[W-1]), 256'(0));
        end
        chk("t6_count0", 256'(count), 256'(0));

        repeat (2) step('0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sl_pipe_fifo.md
Name: sl_pipe_fifo

Overview:
- Single-clock successor to the dual-clock valid-in-MSB sync stage.
- Input register pipeline feeds a DEPTH-deep circular buffer; pops feed an output register pipeline.
- Adds consumer backpressure (rd_ready), occupancy/almost-full reporting and overflow accounting.
- Used between SL processing stages that share one clock but need elastic buffering plus retiming stages for timing closure.

Parameters:
- WIDTH, 193, total word width; bit WIDTH-1 is the valid flag, bits WIDTH-2:0 are the payload.
- DEPTH, 16, buffer entries; must be a power of 2 and ≥ 2.
- NSTAGES_IN, 2, input register stages; must be ≥ 1.
- NSTAGES_OUT, 2, output register stages; must be ≥ 1.
- AFULL_LVL, 14, count at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  input word; MSB is valid.
- rd_ready  in  1  consumer requests a pop this cycle.
- data_out  out  WIDTH  output word; MSB is valid.
- count  out  $clog2(DEPTH)+1  buffer occupancy.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AFULL_LVL.
- ovf_sticky  out  1  a valid word was dropped since the last clear.
- ovf_count  out  16  number of dropped words, saturating.
- clr_ovf  in  1  synchronous clear of ovf_sticky and ovf_count.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; all outputs and state go to 0, except empty = 1.
  - All in-stages, out-stages, pointers and count are cleared.
  - Reset mid-operation discards all buffered and in-flight words.
- Input pipe:
  - Free-running; data_in is shifted through NSTAGES_IN registers, with no backpressure.
  - Last stage word W issues a push on the edge when W[WIDTH-1] = 1.
  - Net: data_in sampled valid at edge k is pushed at edge k+NSTAGES_IN.
- Push:
  - Writes the full WIDTH word to mem[wr_ptr]; wr_ptr increments and wraps at DEPTH.
- Pop:
  - Occurs when rd_ready = 1 and count > 0 at the edge.
  - Loads mem[rd_ptr] into out-stage 0; rd_ptr increments and wraps.
- No pop:
  - Out-stage 0 valid bit goes to 0; its payload bits hold their previous value.
- Output pipe:
  - Free-running shift through NSTAGES_OUT registers; data_out is the last stage.
  - Word popped at edge k is visible on data_out after edge k+NSTAGES_OUT-1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
  - empty, full and almost_full are decoded from the registered count.
- Full boundary:
  - A push with count == DEPTH and no pop that edge is dropped; buffer and pointers are unchanged.
  - A push with count == DEPTH and a simultaneous pop is accepted; count stays at DEPTH.
- Empty boundary:
  - A push and rd_ready in the same edge with count == 0 accepts the push only; there is no bypass.
  - The word becomes poppable on the next edge.
- Overflow:
  - Each dropped push sets ovf_sticky and increments ovf_count, saturating at 0xFFFF.
  - clr_ovf has priority: if a drop coincides with clr_ovf, the result is ovf_sticky = 0, ovf_count = 0.
- Invalid words (MSB = 0) never enter the buffer.

Optional Feature:
- Macro: SL_PIPE_FIFO_OVF_CNT_EN.
- Defined: ovf_count is implemented as specified above.
- Undefined: the counter is not built, ovf_count is tied to 0, and ovf_sticky still operates.

Decomposition:
- Shared package sl_pipe_fifo_pkg contains:
  - the OVF_CNT_W = 16 constant;
  - a function returning the count width for DEPTH;
  - the VALID_BIT index helper (WIDTH-1).
- One natural sub-module, sl_shift_pipe (WIDTH, NSTAGES, async active-low reset, free-running), instantiated for both the input and output pipes.
- Buffer storage and pointer/count logic stay in the top level.

Test Plan:
- Defaults, 5 valid words 0x1_..01..05 at consecutive edges, rd_ready = 0:
  - Expect count = 5 two edges after the last input; data_out valid stays 0.
  - Raise rd_ready: words 01..05 appear in order with valid = 1, first one 1 edge after the first pop, then count = 0 and empty = 1.
- 20 valid words, rd_ready = 0:
  - Expect full = 1 at count = 16, almost_full from count = 14, ovf_sticky = 1, ovf_count = 4.
  - Pulse clr_ovf: expect ovf_sticky = 0 and ovf_count = 0.
- Buffer full, valid push with rd_ready = 1 on the same edge:
  - Expect the push accepted, count stays 16, ovf_count unchanged.
  - Pointer wrap: buffer content reads back in order across the wrap.
- count = 0, valid push and rd_ready coincide:
  - Expect no pop on that edge, count = 1.
  - Pop on the next edge; data_out valid 1 edge later.
- Mixed valid and invalid input (MSB = 0 on alternate cycles):
  - Expect only valid words counted and buffered.
  - Expect data_out valid = 0 in idle pop cycles with payload held.
- rst_n driven low mid-stream, asynchronously between edges, with count = 7:
  - Expect all outputs 0 immediately, with empty = 1.
  - After release, expect nothing from before the reset on data_out.
- Compile without SL_PIPE_FIFO_OVF_CNT_EN: expect ovf_count = 0 throughout, with ovf_sticky still asserting on drops.
